// File: rtl/memory_arbiter.sv
// Fetch/data arbiter in front of the single-port memory controller.
// Data wins ties unless fetch has been starved STARVE_LIMIT cycles.
module memory_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_gnt,
  output logic [31:0]           f_rdata,
  output logic                  f_valid,
  output logic                  f_abort,
  input  logic                  d_req,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_gnt,
  output logic [31:0]           d_rdata,
  output logic                  d_valid,
  output logic                  d_abort,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [31:0]           m_wdata,
  output logic                  m_write,
  output logic [1:0]            m_trans,
  input  logic [31:0]           m_rdata,
  input  logic                  m_abort
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH-1:0] ONE =
    {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE, FETCH_RD, DATA_RD, DATA_WR
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE, OWN_F, OWN_D
  } own_t;

  state_t                r_state;
  own_t                  r_prev_own;
  logic [ADDR_WIDTH-1:0] r_prev_addr;
  logic [SW-1:0]         r_starve;
  logic [ADDR_WIDTH-1:0] r_m_addr;
  logic [31:0]           r_m_wdata;
  logic                  r_m_write;
  logic [1:0]            r_m_trans;
  logic                  r_f_valid;
  logic                  r_d_valid;

  logic                  w_starved;
  logic                  w_acc;
  logic                  w_store;
  logic                  w_seq;
  own_t                  w_own;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] w_next;

  assign w_starved = (r_starve == LIM);

  assign f_gnt = !reset && f_req && (!d_req || w_starved);
  assign d_gnt = !reset && d_req && !(f_req && w_starved);

  assign w_acc   = f_gnt || d_gnt;
  assign w_store = d_gnt && d_write;
  assign w_addr  = d_gnt ? d_addr : f_addr;
  assign w_own   = d_gnt ? OWN_D : OWN_F;
  assign w_next  = r_prev_addr + ONE;
  assign w_seq   = (r_prev_own == w_own) &&
                   (w_addr == w_next);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
    end else if (!f_req || f_gnt) begin
      r_starve <= '0;
    end else if (!w_starved) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  // r_state names the slot on the bus this cycle;
  // its read data returns one edge later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_prev_own  <= OWN_NONE;
      r_prev_addr <= '0;
      r_m_addr    <= '0;
      r_m_wdata   <= '0;
      r_m_write   <= 1'b0;
      r_m_trans   <= 2'b00;
      r_f_valid   <= 1'b0;
      r_d_valid   <= 1'b0;
    end else begin
      r_f_valid <= (r_state == FETCH_RD);
      r_d_valid <= (r_state == DATA_RD);
      if (w_acc) begin
        r_m_addr    <= w_addr;
        r_m_write   <= w_store;
        r_m_trans   <= w_seq ? 2'b11 : 2'b10;
        r_prev_own  <= w_own;
        r_prev_addr <= w_addr;
        if (w_store) begin
          r_m_wdata <= d_wdata;
        end
        unique case (1'b1)
          f_gnt:   r_state <= FETCH_RD;
          w_store: r_state <= DATA_WR;
          default: r_state <= DATA_RD;
        endcase
      end else begin
        r_m_write <= 1'b0;
        r_m_trans <= 2'b00;
        r_state   <= IDLE;
      end
    end
  end

  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign m_write = r_m_write;
  assign m_trans = r_m_trans;

  assign f_valid = r_f_valid;
  assign d_valid = r_d_valid;
  assign f_rdata = r_f_valid ? m_rdata : 32'h0;
  assign d_rdata = r_d_valid ? m_rdata : 32'h0;
  assign f_abort = r_f_valid && m_abort;
  assign d_abort = r_d_valid && m_abort;

endmodule

// File: tb/tb_memory_arbiter.sv
// Random and directed bench for memory_arbiter against a
// transaction-level reference with a simple memory model.
module tb_memory_arbiter;

  localparam int AW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          f_req, d_req, d_write;
  logic [AW-1:0] f_addr, d_addr;
  logic [31:0]   d_wdata;
  logic          f_gnt, d_gnt;
  logic [31:0]   f_rdata, d_rdata;
  logic          f_valid, d_valid, f_abort, d_abort;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic          m_write;
  logic [1:0]    m_trans;
  logic [31:0]   m_rdata = 32'h0;
  logic          m_abort = 1'b0;

  always #5 clk = ~clk;

  memory_arbiter #(
    .ADDR_WIDTH(AW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
    .f_rdata(f_rdata), .f_valid(f_valid), .f_abort(f_abort),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rdata(d_rdata),
    .d_valid(d_valid), .d_abort(d_abort),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_write(m_write),
    .m_trans(m_trans), .m_rdata(m_rdata), .m_abort(m_abort)
  );

  function automatic logic [31:0] init_word(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic bit abort_addr(logic [31:0] a);
    return a[15:0] == 16'hFFFF;
  endfunction

  // memory environment: registered read, write at sample edge
  logic [31:0] mem [logic [31:0]];
  always @(posedge clk) begin
    if (m_trans[1]) begin
      if (m_write) begin
        mem[m_addr] = m_wdata;
      end else begin
        m_rdata <= mem.exists(m_addr) ? mem[m_addr]
                                      : init_word(m_addr);
        m_abort <= abort_addr(m_addr);
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model
  typedef struct {
    bit          is_f;
    logic [31:0] data;
    bit          ab;
    int          due;
  } ret_t;

  ret_t        rq[$];
  logic [31:0] ref_mem [logic [31:0]];
  int          starve   = 0;
  int          edge_n   = 0;
  int          last_own = 0;
  logic [31:0] last_addr = '0;
  logic [1:0]  e_trans = 2'b00;
  logic [31:0] e_addr  = '0;
  logic [31:0] e_wdata = '0;
  bit          e_write = 0;
  bit          eg_f, eg_d;
  bit          seen_fg, seen_dg;
  int          fv_cnt = 0;
  logic [31:0] last_drd = '0;

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic step();
    bit          xfv, xdv;
    logic [31:0] xfd, xdd;
    bit          xfa, xda;
    ret_t        r;
    logic [31:0] a;
    int          own;
    @(negedge clk);
    eg_f = 0;
    eg_d = 0;
    if (!reset) begin
      if (d_req && !(f_req && starve == LIM)) eg_d = 1;
      else if (f_req) eg_f = 1;
    end
    seen_fg = f_gnt;
    seen_dg = d_gnt;
    chk("f_gnt", f_gnt, eg_f);
    chk("d_gnt", d_gnt, eg_d);
    chk("m_trans", m_trans, e_trans);
    chk("m_addr", m_addr, e_addr);
    chk("m_write", m_write, e_write);
    chk("m_wdata", m_wdata, e_wdata);
    xfv = 0; xdv = 0; xfd = 0; xdd = 0; xfa = 0; xda = 0;
    if (rq.size() > 0 && rq[0].due == edge_n) begin
      r = rq.pop_front();
      if (r.is_f) begin
        xfv = 1; xfd = r.data; xfa = r.ab;
      end else begin
        xdv = 1; xdd = r.data; xda = r.ab;
      end
    end
    chk("f_valid", f_valid, xfv);
    chk("d_valid", d_valid, xdv);
    chk("f_rdata", f_rdata, xfd);
    chk("d_rdata", d_rdata, xdd);
    chk("f_abort", f_abort, xfa);
    chk("d_abort", d_abort, xda);
    if (f_valid) fv_cnt++;
    if (d_valid) last_drd = d_rdata;
    @(posedge clk);
    edge_n++;
    if (reset) begin
      starve = 0;
      rq.delete();
      last_own = 0;
      last_addr = '0;
      e_trans = 2'b00;
      e_write = 0;
      e_addr = '0;
      e_wdata = '0;
    end else begin
      if (eg_f || eg_d) begin
        a   = eg_d ? d_addr : f_addr;
        own = eg_d ? 2 : 1;
        e_trans = (own == last_own && a == last_addr + 32'd1)
                  ? 2'b11 : 2'b10;
        e_addr  = a;
        e_write = eg_d && d_write;
        if (e_write) begin
          e_wdata = d_wdata;
          ref_mem[a] = d_wdata;
        end else begin
          rq.push_back('{is_f: eg_f, data: ref_rd(a),
                         ab: abort_addr(a), due: edge_n + 1});
        end
        last_own  = own;
        last_addr = a;
      end else begin
        e_trans = 2'b00;
        e_write = 0;
      end
      if (!f_req || eg_f) starve = 0;
      else if (starve < LIM) starve++;
    end
    #1;
  endtask

  task automatic idle(input int n);
    f_req = 0;
    d_req = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_f(input logic [31:0] a);
    int n = 0;
    f_req  = 1;
    f_addr = a;
    do begin
      step();
      n++;
    end while (!seen_fg && n < 20);
    chk("f_wait", seen_fg, 1);
    f_req = 0;
  endtask

  task automatic do_d(input bit wr, input logic [31:0] a,
                      input logic [31:0] wd);
    int n = 0;
    d_req   = 1;
    d_write = wr;
    d_addr  = a;
    d_wdata = wd;
    do begin
      step();
      n++;
    end while (!seen_dg && n < 20);
    chk("d_wait", seen_dg, 1);
    d_req = 0;
  endtask

  initial begin
    int fcnt;
    reset = 1; f_req = 0; d_req = 0; d_write = 0;
    f_addr = '0; d_addr = '0; d_wdata = '0;
    #1;
    step();
    step();
    reset = 0;

    // sequential fetch burst 0,1,2
    f_req = 1;
    for (int i = 0; i < 3; i++) begin
      f_addr = i;
      step();
    end
    idle(3);

    // store then load of the same word
    do_d(1, 32'h40, 32'hDEADBEEF);
    do_d(0, 32'h40, 32'h0);
    idle(3);
    chk("t2_load", last_drd, 32'hDEADBEEF);

    // both held: four data grants then one fetch grant
    f_req = 1; d_req = 1; d_write = 0;
    f_addr = 32'h100; d_addr = 32'h200;
    fcnt = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (seen_fg) begin
        fcnt++;
        f_addr = f_addr + 1;
      end
      if (seen_dg) d_addr = $urandom_range(255, 0);
    end
    chk("t3_fgrants", fcnt, 5);
    idle(3);

    // owner change breaks sequential
    do_f(32'h10);
    do_d(0, 32'h11, 32'h0);
    idle(3);

    // reset kills an in-flight read
    do_f(32'h20);
    fv_cnt = 0;
    reset = 1;
    step();
    reset = 0;
    step();
    step();
    chk("t5_no_valid", fv_cnt, 0);
    do_f(32'h21);
    idle(3);

    // address wrap stays sequential, abort on first read
    f_req = 1;
    f_addr = 32'hFFFFFFFF;
    step();
    f_addr = 32'h0;
    step();
    idle(3);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(99, 0) == 0);
      step();
      if (!f_req || seen_fg) begin
        f_req = ($urandom_range(3, 0) != 0);
        case ($urandom_range(7, 0))
          0: f_addr = $urandom;
          1: f_addr = 32'hFFFFFFFE;
          2: f_addr = $urandom_range(63, 0);
          default: f_addr = f_addr + 1;
        endcase
      end
      if (!d_req || seen_dg) begin
        d_req   = ($urandom_range(2, 0) != 0);
        d_write = $urandom_range(1, 0);
        d_wdata = $urandom;
        d_addr  = ($urandom_range(3, 0) == 0) ? d_addr + 1
                : 32'($urandom_range(63, 0));
      end
    end
    reset = 0;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
